// File: rtl/rtc_bus_pkg.sv
// Shared types and default timing for the RTC bus sequencer.
// Optional build macro: BUS_TIMEOUT_EN enables the RUN-state watchdog.
package rtc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0] T_ADR_LO_DEF  = 9'd10;
    localparam logic [8:0] T_ADR_HI_DEF  = 9'd60;
    localparam logic [8:0] T_DAT_LO_DEF  = 9'd170;
    localparam logic [8:0] T_DAT_HI_DEF  = 9'd220;
    localparam logic [8:0] T_BUS_REL_DEF = 9'd260;
    localparam logic [8:0] T_SAMPLE_DEF  = 9'd215;
    localparam logic [8:0] CNT_TERM      = 9'd350;

    localparam int WDOG_W     = 10;
    localparam int WDOG_LIMIT = 512;

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Host request, timing-counter and RTC bus signals of the sequencer.
interface rtc_bus_sequencer_if;
    logic       req;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic       done;
    logic [7:0] rdata;
    logic       err;
    logic       cnt_en;
    logic [8:0] cnt_val;
    logic       cnt_fin;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_n;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    modport master (
        output req, rw, addr, wdata, cnt_val, cnt_fin, ad_in,
        input  ready, done, rdata, err, cnt_en,
        input  cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
    );

    modport slave (
        input  req, rw, addr, wdata, cnt_val, cnt_fin, ad_in,
        output ready, done, rdata, err, cnt_en,
        output cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_sequencer_bus_watchdog.sv
// Free-running RUN-state watchdog; expires on the last cycle of the limit.
module bus_watchdog
    import rtc_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic [WDOG_W-1:0] count,
    output logic              expire
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == WDOG_W'(WDOG_LIMIT - 1));

endmodule

// File: rtl/rtc_bus_sequencer.sv
// RTC multiplexed-bus transaction sequencer driven by an external 9-bit counter.
// Optional build macro: BUS_TIMEOUT_EN adds the watchdog and the err flag.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter logic [8:0] T_ADR_LO  = T_ADR_LO_DEF,
    parameter logic [8:0] T_ADR_HI  = T_ADR_HI_DEF,
    parameter logic [8:0] T_DAT_LO  = T_DAT_LO_DEF,
    parameter logic [8:0] T_DAT_HI  = T_DAT_HI_DEF,
    parameter logic [8:0] T_BUS_REL = T_BUS_REL_DEF,
    parameter logic [8:0] T_SAMPLE  = T_SAMPLE_DEF
) (
    input  logic clk,
    input  logic reset,
    rtc_bus_sequencer_if.slave bus
);

    if (!(T_ADR_LO < T_ADR_HI && T_ADR_HI < T_DAT_LO &&
          T_DAT_LO < T_SAMPLE && T_SAMPLE < T_DAT_HI &&
          T_DAT_HI < T_BUS_REL && T_BUS_REL < CNT_TERM)) begin : g_bad_order
        $error("rtc_bus_sequencer: phase thresholds out of order");
    end

    state_t     state, state_nxt;
    logic       rw_q;
    logic [7:0] addr_q, wdata_q, shadow_q, rdata_q;
    logic       cs_q, rd_q, wr_q, ad_q, oe_q;
    logic [7:0] out_q;
    logic       err_q, timeout;
    logic       run, accept;
    logic       adr_win, adr_strb, dat_strb, dat_drv;
    logic [8:0] c;

    assign c      = bus.cnt_val;
    assign run    = (state == RUN);
    assign accept = (state == IDLE) && bus.req;

    assign adr_win  = (c != 9'd0) && (c < T_DAT_LO);
    assign adr_strb = (c >= T_ADR_LO) && (c < T_ADR_HI);
    assign dat_strb = (c >= T_DAT_LO) && (c < T_DAT_HI);
    assign dat_drv  = (c >= T_DAT_LO) && (c < T_BUS_REL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.req) state_nxt = RUN;
            RUN:     if (bus.cnt_fin || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                rw_q    <= bus.rw;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (run && c == T_SAMPLE) shadow_q <= bus.ad_in;
            // Publish on DONE entry so rdata is already valid while done is high.
            if (run && bus.cnt_fin && rw_q) rdata_q <= shadow_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_q  <= 1'b1;
            rd_q  <= 1'b1;
            wr_q  <= 1'b1;
            ad_q  <= 1'b1;
            oe_q  <= 1'b0;
            out_q <= '0;
        end else begin
            cs_q <= !(run && (adr_strb || dat_strb));
            rd_q <= !(run && rw_q && dat_strb);
            wr_q <= !(run && (adr_strb || (!rw_q && dat_strb)));
            ad_q <= !(run && adr_win);
            oe_q <= run && (adr_win || (!rw_q && dat_drv));
            if (run && adr_win)                 out_q <= addr_q;
            else if (run && !rw_q && dat_drv)   out_q <= wdata_q;
            else                                out_q <= '0;
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [WDOG_W-1:0] wd_count;
    logic              wd_expire;

    bus_watchdog u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!run),
        .count  (wd_count),
        .expire (wd_expire)
    );

    assign timeout = wd_expire && (wd_count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               err_q <= 1'b0;
        else if (accept)                          err_q <= 1'b0;
        else if (run && timeout && !bus.cnt_fin)  err_q <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign err_q   = 1'b0;
`endif

    assign bus.ready  = (state == IDLE);
    assign bus.done   = (state == DONE);
    assign bus.cnt_en = run;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
    assign bus.cs_n   = cs_q;
    assign bus.rd_n   = rd_q;
    assign bus.wr_n   = wr_q;
    assign bus.ad_n   = ad_q;
    assign bus.ad_oe  = oe_q;
    assign bus.ad_out = out_q;

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Transaction sequencer for the RTC chip's multiplexed address/data parallel bus. It sits directly upstream of the 9-bit transaction timing counter: it drives the counter's enable, decodes the returned count into bus strobes, and retires the transaction when the counter reports its terminal count. Upstream control logic issues one read or write request at a time and receives a done pulse plus read data.

## Interface
- T_ADR_LO, 10: count at which address-phase CS/WR go low
- T_ADR_HI, 60: count at which address-phase strobes return high
- T_DAT_LO, 170: count at which data-phase CS/RD or CS/WR go low
- T_DAT_HI, 220: count at which data-phase strobes return high
- T_BUS_REL, 260: count at which the bus driver is released
- T_SAMPLE, 215: count at which read data is captured
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- req  in  1  transaction request, qualified by ready
- rw  in  1  1 = read, 0 = write; captured with req
- addr  in  8  RTC register address; captured with req
- wdata  in  8  write data; captured with req
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse at transaction end
- rdata  out  8  read data; valid from done, held until next read's done
- err  out  1  timeout flag (see Configuration)
- cnt_en  out  1  enable to timing counter
- cnt_val  in  9  counter value
- cnt_fin  in  1  counter terminal-count flag (count = 350)
- cs_n, rd_n, wr_n, ad_n  out  1 each  RTC bus strobes, registered
- ad_out  out  8  bus drive value
- ad_oe  out  1  bus drive enable; the top level builds the tristate
- ad_in  in  8  bus sample value

## Operation
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - ready=1, cnt_en=0.
  - req=1 captures rw, addr, wdata and goes to RUN.
  - req outside IDLE is ignored. It is not queued.
- RUN:
  - cnt_en=1.
  - Strobes are decoded from cnt_val (c) and registered.
  - Address phase: ad_n=0 for 1 ≤ c < T_DAT_LO.
  - Address phase: cs_n=0 and wr_n=0 for T_ADR_LO ≤ c < T_ADR_HI.
  - ad_out=addr and ad_oe=1 for 1 ≤ c < T_DAT_LO.
  - Data phase: ad_n=1. cs_n=0 for T_DAT_LO ≤ c < T_DAT_HI.
  - Data phase: in the same window, rd_n=0 on a read or wr_n=0 on a write.
  - Write: ad_out=wdata and ad_oe=1 for T_DAT_LO ≤ c < T_BUS_REL.
  - Read: ad_oe=0 throughout the data phase.
  - Read capture: ad_in is registered into the rdata shadow when c == T_SAMPLE.
  - cnt_fin=1 -> DONE.
- DONE:
  - cnt_en=0, so the counter returns to 0 on this edge.
  - done=1. On a read, rdata is updated from the shadow.
  - Unconditionally returns to IDLE.
- Outside the active windows: cs_n=rd_n=wr_n=ad_n=1, ad_oe=0.
- Parameter ordering T_ADR_LO < T_ADR_HI < T_DAT_LO < T_SAMPLE < T_DAT_HI < T_BUS_REL < 350 is a requirement. A violation is an elaboration-time error.

## Timing
- Reset values: state=IDLE, ready=1, done=0, rdata=0x00, err=0, cnt_en=0, cs_n=rd_n=wr_n=ad_n=1, ad_out=0x00, ad_oe=0.
- Strobe outputs lag cnt_val by one clock because the decode is registered.
- Latency:
  - req accepted at edge N -> cnt_en high from N.
  - cnt_val=350 reached about 351 cycles later.
  - cnt_fin seen -> DONE -> done high for exactly 1 cycle.
  - ready high on the following cycle.
- Minimum spacing between accepted requests is 353 cycles.
- Reset asserted mid-transaction: all outputs return to reset values immediately. No partial strobe is completed, and rdata clears.
- cnt_fin and req in the same cycle: req is ignored (state is not IDLE).

## Configuration
- BUS_TIMEOUT_EN defined:
  - A 10-bit watchdog runs in RUN.
  - If 512 cycles elapse without cnt_fin, the FSM goes to DONE: done=1, err=1, rdata unchanged.
  - err holds until the next accepted req.
- BUS_TIMEOUT_EN undefined: no watchdog, err tied to 0, RUN waits indefinitely.

## Structure
- Shared package rtc_bus_pkg holds:
  - the state encoding (IDLE/RUN/DONE);
  - the default phase thresholds;
  - the terminal count 350;
  - the watchdog limit 512.
- One sub-module, bus_watchdog: count, clear, and expire outputs. It is instantiated only under BUS_TIMEOUT_EN.

## Test plan
- Write addr=0x21, wdata=0x55:
  - ad_out=0x21 with wr_n low for c 10..59;
  - ad_out=0x55 with wr_n low for c 170..219;
  - ad_oe drops at c=260;
  - done one cycle after cnt_fin; rd_n stays 1.
- Read addr=0x03, ad_in=0xA7 at c=215 (0x00 elsewhere): rdata=0xA7 at done, ad_oe=0 during the data phase, wr_n=1 in the data phase.
- req pulsed at c=100 during a write: ignored. The bus trace is identical to the lone write, and exactly one done pulse occurs.
- reset low at c=180 during a read: strobes immediately 1, ad_oe=0, state IDLE, rdata=0x00. A fresh read then completes normally.
- Back-to-back: req held high continuously gives two transactions 353 cycles apart. The counter is observed at 0 at each start.
- BUS_TIMEOUT_EN with cnt_fin forced 0: done and err assert 512 cycles after accept, and err clears on the next req.
